// File: rtl/btn_evt_pkg.sv
// Shared encodings for the pushbutton event controller: event types and per-button FSM states.
package btn_evt_pkg;

  typedef enum logic [1:0] {
    EVT_PRESS   = 2'd0,
    EVT_LONG    = 2'd1,
    EVT_REPEAT  = 2'd2,
    EVT_RELEASE = 2'd3
  } evt_type_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HELD    = 2'd2
  } state_t;

endpackage

// File: rtl/btn_press_fsm.sv
// Per-button press / long-press / auto-repeat FSM, advanced only on sample ticks.
// RELEASE_EVT_EN: when defined, returning to IDLE emits a RELEASE event.
module btn_press_fsm
  import btn_evt_pkg::*;
#(
  parameter int unsigned LONG_TICKS   = 50,
  parameter int unsigned REPEAT_TICKS = 10
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      i_tick,
  input  logic      i_btn,
  output logic      o_emit,
  output evt_type_t o_type
);

  // Wide enough for whichever of the two periods is larger.
  localparam int unsigned CNT_MAX = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  state_t             r_state, w_state_nx;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    o_emit     = 1'b0;
    o_type     = EVT_PRESS;
    if (i_tick) begin
      case (r_state)
        ST_IDLE: begin
          if (i_btn) begin
            w_state_nx = ST_PRESSED;
            w_cnt_nx   = '0;
            o_emit     = 1'b1;
            o_type     = EVT_PRESS;
          end
        end
        ST_PRESSED, ST_HELD: begin
          if (!i_btn) begin
            w_state_nx = ST_IDLE;
`ifdef RELEASE_EVT_EN
            o_emit     = 1'b1;
            o_type     = EVT_RELEASE;
`endif
          end else if (r_state == ST_PRESSED && r_cnt == CNT_W'(LONG_TICKS - 1)) begin
            w_state_nx = ST_HELD;
            w_cnt_nx   = '0;
            o_emit     = 1'b1;
            o_type     = EVT_LONG;
          end else if (r_state == ST_HELD && r_cnt == CNT_W'(REPEAT_TICKS - 1)) begin
            w_cnt_nx   = '0;
            o_emit     = 1'b1;
            o_type     = EVT_REPEAT;
          end else begin
            w_cnt_nx   = r_cnt + CNT_W'(1);
          end
        end
        default: w_state_nx = ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/button_event_ctrl.sv
// Sample-tick divider, per-button event FSMs, pending slots, round-robin arbiter and drop flag.
// RELEASE_EVT_EN: when defined, button releases produce RELEASE events.
module button_event_ctrl
  import btn_evt_pkg::*;
#(
  parameter int unsigned N_BTN        = 4,
  parameter int unsigned TICK_DIV     = 100000,
  parameter int unsigned LONG_TICKS   = 50,
  parameter int unsigned REPEAT_TICKS = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      sample_tick,
  input  logic [N_BTN-1:0]          btn_db,
  output logic                      evt_valid,
  input  logic                      evt_ready,
  output logic [$clog2(N_BTN)-1:0]  evt_id,
  output logic [1:0]                evt_type,
  output logic                      drop_flag,
  input  logic                      drop_clr
);

  localparam int unsigned DIV_W = $clog2(TICK_DIV);
  localparam int unsigned ID_W  = $clog2(N_BTN);

  logic [DIV_W-1:0] r_div;
  logic [N_BTN-1:0] r_slot_vld;
  evt_type_t        r_slot_type [N_BTN];
  logic             r_out_vld;
  logic [ID_W-1:0]  r_out_id;
  evt_type_t        r_out_type;
  logic [ID_W-1:0]  r_rr;
  logic             r_drop;

  logic [N_BTN-1:0] w_emit;
  evt_type_t        w_type [N_BTN];
  logic             w_load;
  logic             w_gnt;
  logic [ID_W-1:0]  w_gnt_idx;
  logic [ID_W-1:0]  w_idx;
  logic [N_BTN-1:0] w_clr;
  logic [N_BTN-1:0] w_drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_div <= '0;
    else if (r_div == DIV_W'(TICK_DIV - 1))
      r_div <= '0;
    else
      r_div <= r_div + DIV_W'(1);
  end

  assign sample_tick = (r_div == DIV_W'(TICK_DIV - 1));

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    btn_press_fsm #(
      .LONG_TICKS   (LONG_TICKS),
      .REPEAT_TICKS (REPEAT_TICKS)
    ) u_fsm (
      .clk    (clk),
      .rst    (rst),
      .i_tick (sample_tick),
      .i_btn  (btn_db[g]),
      .o_emit (w_emit[g]),
      .o_type (w_type[g])
    );
  end

  // The output register refills in the same cycle it is accepted, so ready held high streams events.
  always_comb begin
    w_load    = !r_out_vld || evt_ready;
    w_gnt     = 1'b0;
    w_gnt_idx = '0;
    w_idx     = '0;
    for (int unsigned k = 0; k < N_BTN; k++) begin
      if (32'(r_rr) + k >= N_BTN)
        w_idx = ID_W'(32'(r_rr) + k - N_BTN);
      else
        w_idx = ID_W'(32'(r_rr) + k);
      if (w_load && !w_gnt && r_slot_vld[w_idx]) begin
        w_gnt     = 1'b1;
        w_gnt_idx = w_idx;
      end
    end
    for (int unsigned k = 0; k < N_BTN; k++) begin
      w_clr[k]  = w_gnt && (w_gnt_idx == ID_W'(k));
      w_drop[k] = w_emit[k] && r_slot_vld[k] && !w_clr[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot_vld <= '0;
      for (int unsigned k = 0; k < N_BTN; k++) r_slot_type[k] <= EVT_PRESS;
      r_out_vld  <= 1'b0;
      r_out_id   <= '0;
      r_out_type <= EVT_PRESS;
      r_rr       <= '0;
      r_drop     <= 1'b0;
    end else begin
      if (w_load) begin
        r_out_vld <= w_gnt;
        if (w_gnt) begin
          r_out_id   <= w_gnt_idx;
          r_out_type <= r_slot_type[w_gnt_idx];
          r_rr       <= (w_gnt_idx == ID_W'(N_BTN - 1)) ? '0 : w_gnt_idx + ID_W'(1);
        end
      end
      // An emit into a slot being granted this cycle wins; otherwise a full slot keeps its event.
      for (int unsigned k = 0; k < N_BTN; k++) begin
        if (w_emit[k] && !w_drop[k]) begin
          r_slot_vld[k]  <= 1'b1;
          r_slot_type[k] <= w_type[k];
        end else if (w_clr[k]) begin
          r_slot_vld[k]  <= 1'b0;
        end
      end
      if (|w_drop)
        r_drop <= 1'b1;
      else if (drop_clr)
        r_drop <= 1'b0;
    end
  end

  assign evt_valid = r_out_vld;
  assign evt_id    = r_out_id;
  assign evt_type  = r_out_type;
  assign drop_flag = r_drop;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Bench for button_event_ctrl: directed scenarios plus randomized stimulus against a behavioural model.
module tb_button_event_ctrl;

  localparam int N  = 4;
  localparam int TD = 4;
  localparam int LT = 8;
  localparam int RT = 4;
`ifdef RELEASE_EVT_EN
  localparam bit REL_EN = 1'b1;
`else
  localparam bit REL_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sample_tick;
  logic [N-1:0] btn_db = '0;
  logic         evt_valid;
  logic         evt_ready = 1'b1;
  logic [1:0]   evt_id;
  logic [1:0]   evt_type;
  logic         drop_flag;
  logic         drop_clr = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  int ncyc  = 0;
  int log_ev[$];
  int log_cyc[$];

  button_event_ctrl #(
    .N_BTN        (N),
    .TICK_DIV     (TD),
    .LONG_TICKS   (LT),
    .REPEAT_TICKS (RT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_tick (sample_tick),
    .btn_db      (btn_db),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_id      (evt_id),
    .evt_type    (evt_type),
    .drop_flag   (drop_flag),
    .drop_clr    (drop_clr)
  );

  always #5 clk = ~clk;

  // Behavioural model: hold durations in ticks, pending flags, one output register.
  int m_cyc;
  int m_held  [N];
  bit m_pend  [N];
  int m_ptype [N];
  bit m_ov;
  int m_oid;
  int m_otype;
  int m_rr;
  bit m_drop;

  task automatic model_reset();
    m_cyc = 0; m_ov = 0; m_oid = 0; m_otype = 0; m_rr = 0; m_drop = 0;
    for (int i = 0; i < N; i++) begin
      m_held[i] = 0; m_pend[i] = 0; m_ptype[i] = 0;
    end
  endtask

  task automatic model_step();
    bit tick, free, dropped;
    int g;
    bit em [N];
    int et [N];
    if (rst) begin
      model_reset();
      return;
    end
    tick    = (m_cyc % TD) == TD - 1;
    free    = !m_ov || evt_ready;
    dropped = 0;
    g       = -1;
    if (free)
      for (int k = 0; k < N; k++)
        if (g < 0 && m_pend[(m_rr + k) % N]) g = (m_rr + k) % N;
    for (int i = 0; i < N; i++) begin
      em[i] = 0; et[i] = 0;
      if (tick) begin
        if (btn_db[i]) begin
          if (m_held[i] == 0) begin em[i] = 1; et[i] = 0; end
          else if (m_held[i] == LT) begin em[i] = 1; et[i] = 1; end
          else if (m_held[i] > LT && (m_held[i] - LT) % RT == 0) begin em[i] = 1; et[i] = 2; end
          m_held[i]++;
        end else begin
          if (m_held[i] > 0 && REL_EN) begin em[i] = 1; et[i] = 3; end
          m_held[i] = 0;
        end
      end
    end
    if (free) begin
      if (g >= 0) begin
        m_ov = 1; m_oid = g; m_otype = m_ptype[g]; m_pend[g] = 0; m_rr = (g + 1) % N;
      end else begin
        m_ov = 0;
      end
    end
    for (int i = 0; i < N; i++)
      if (em[i]) begin
        if (m_pend[i]) dropped = 1;
        else begin m_pend[i] = 1; m_ptype[i] = et[i]; end
      end
    if (dropped) m_drop = 1;
    else if (drop_clr) m_drop = 0;
    m_cyc++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_seq(input string nm, input int id, input int exp[$]);
    int got[$];
    foreach (log_ev[k]) if (log_ev[k] / 4 == id) got.push_back(log_ev[k] % 4);
    chk({nm, " count"}, got.size(), exp.size());
    foreach (exp[k]) if (k < got.size()) chk(nm, got[k], exp[k]);
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic hold(input logic [N-1:0] b, input int ticks);
    btn_db = b;
    step(ticks * TD);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    ncyc++;
    chk("sample_tick", sample_tick, ((m_cyc % TD) == TD - 1) ? 1 : 0);
    chk("evt_valid", evt_valid, m_ov);
    chk("drop_flag", drop_flag, m_drop);
    if (m_ov) begin
      chk("evt_id", evt_id, m_oid);
      chk("evt_type", evt_type, m_otype);
    end
    if (evt_valid && evt_ready && !rst) begin
      log_ev.push_back(int'(evt_id) * 4 + int'(evt_type));
      log_cyc.push_back(ncyc);
    end
  end

  initial begin
    int exp[$];
    int waited;
    model_reset();
    step(2);
    chk("reset evt_valid", evt_valid, 0);
    chk("reset drop_flag", drop_flag, 0);
    chk("reset sample_tick", sample_tick, 0);
    rst = 1'b0;

    // Long hold on button 0.
    log_ev.delete(); log_cyc.delete();
    hold(4'b0001, 20);
    hold(4'b0000, 4);
    exp.delete();
    exp.push_back(0); exp.push_back(1); exp.push_back(2); exp.push_back(2);
    if (REL_EN) exp.push_back(3);
    chk_seq("long_hold", 0, exp);
    chk("long_hold drop", drop_flag, 0);

    // All buttons in one tick, round-robin pointer at 1.
    log_ev.delete(); log_cyc.delete();
    hold(4'b1111, 1);
    hold(4'b0000, 3);
    chk("simul count", (log_ev.size() >= 4) ? 1 : 0, 1);
    if (log_ev.size() >= 4) begin
      chk("simul 0", log_ev[0], 1 * 4);
      chk("simul 1", log_ev[1], 2 * 4);
      chk("simul 2", log_ev[2], 3 * 4);
      chk("simul 3", log_ev[3], 0 * 4);
      for (int k = 1; k < 4; k++) chk("simul back2back", log_cyc[k] - log_cyc[0], k);
    end

    // Backpressure: output holds button 0 PRESS, button 3 release hits a full slot.
    log_ev.delete(); log_cyc.delete();
    evt_ready = 1'b0;
    hold(4'b0001, 1);
    hold(4'b0000, 1);
    hold(4'b1000, 2);
    hold(4'b0000, 2);
    repeat (10) begin
      chk("stable valid", evt_valid, 1);
      chk("stable id", evt_id, 0);
      chk("stable type", evt_type, 0);
      step();
    end
    chk("bp drop", drop_flag, REL_EN);
    evt_ready = 1'b1;
    step(12);
    exp.delete();
    exp.push_back(0);
    chk_seq("bp id3", 3, exp);
    drop_clr = 1'b1;
    step();
    drop_clr = 1'b0;
    chk("drop_clr", drop_flag, 0);

    // Reset while an event is presented.
    evt_ready = 1'b0;
    btn_db = 4'b0100;
    waited = 0;
    while (!evt_valid && waited < 20) begin
      step();
      waited++;
    end
    chk("wait valid", evt_valid, 1);
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst evt_valid", evt_valid, 0);
    chk("rst drop_flag", drop_flag, 0);
    chk("rst sample_tick", sample_tick, 0);
    step(2);
    btn_db = '0;
    evt_ready = 1'b1;
    rst = 1'b0;
    chk("post_rst tick0", sample_tick, 0);
    step();
    chk("post_rst tick1", sample_tick, 0);
    step();
    chk("post_rst tick2", sample_tick, 0);
    step();
    chk("post_rst tick3", sample_tick, 1);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      if (c % TD == 0)
        for (int b = 0; b < N; b++)
          if ($urandom_range(0, 7) == 0) btn_db[b] = ~btn_db[b];
      evt_ready = ($urandom_range(0, 3) != 0);
      drop_clr  = ($urandom_range(0, 15) == 0);
      step();
    end
    btn_db = '0;
    evt_ready = 1'b1;
    drop_clr = 1'b0;
    step(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/button_event_ctrl.md
Name: button_event_ctrl

Overview:
- Controller for a bank of debounce shift-register instances, one per pushbutton.
- Generates the slow sample strobe that paces the debouncers and runs a per-button press/long-press/auto-repeat FSM on their debounced levels.
- Round-robin arbitrates the resulting events onto one valid/ready event port for the downstream FSM (counter/display control).

Parameters:
N_BTN, 4, number of buttons (2..8)
TICK_DIV, 100000, clk cycles per sample_tick (>=2)
LONG_TICKS, 50, ticks held before LONG event (>=2)
REPEAT_TICKS, 10, ticks between REPEAT events after LONG (>=1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
sample_tick  out  1  one-clk strobe every TICK_DIV clks; drives the debouncer clock enable
btn_db  in  N_BTN  debounced button levels, 1 = pressed
evt_valid  out  1  event available
evt_ready  in  1  consumer accepts event when evt_valid & evt_ready
evt_id  out  clog2(N_BTN)  button index of event
evt_type  out  2  0=PRESS 1=LONG 2=REPEAT 3=RELEASE
drop_flag  out  1  sticky: an event was lost
drop_clr  in  1  clears drop_flag

Behaviour:
- Reset, asynchronous and active-high: all outputs 0, divider 0, every FSM in IDLE, pending slots empty. Reset mid-event discards all pending and output state.
- Divider: counts 0..TICK_DIV-1 and wraps. sample_tick = 1 in the cycle the count equals TICK_DIV-1.
- btn_db is sampled only in tick cycles. Per-button FSM with tick counter, width clog2(LONG_TICKS+1):
  - IDLE: btn=1 -> PRESSED, cnt=0, emit PRESS.
  - PRESSED: btn=0 -> IDLE, emit RELEASE. Otherwise cnt++; when cnt reaches LONG_TICKS-1 -> HELD, cnt=0, emit LONG.
  - HELD: btn=0 -> IDLE, emit RELEASE. Otherwise cnt++; when cnt reaches REPEAT_TICKS-1 -> cnt=0, emit REPEAT.
- Emit: writes the button's pending slot (valid + type) at the clk edge ending the tick cycle.
- Slot already full when a new event is emitted: newer event dropped, old one kept, drop_flag set.
- drop_clr and a new drop in the same cycle: drop_flag stays 1.
- Arbiter: when the output register is empty, or is being accepted this cycle, it loads the lowest index >= rr_ptr (wrapping) with a pending slot, clears that slot, and sets rr_ptr = index+1 mod N_BTN. This allows back-to-back events with evt_ready held high.
- A slot cleared by the arbiter may be refilled by an emit in the same cycle: the emit wins, the slot ends full.
- Latency: emit in tick cycle T -> slot full at T+1 -> evt_valid at T+2 if the output is free.
- evt_id and evt_type stay stable while evt_valid=1 and evt_ready=0. evt_valid drops only on acceptance with nothing pending.
- All buttons emit in the same tick: N_BTN events are presented in round-robin order, one per accept.

Optional Feature:
- RELEASE_EVT_EN defined: RELEASE events are emitted as described.
- Undefined: PRESSED/HELD -> IDLE transitions still occur but emit nothing. evt_type 3 never appears.

Decomposition:
- Package btn_evt_pkg: evt_type encodings (EVT_PRESS/LONG/REPEAT/RELEASE) and FSM state encodings (ST_IDLE/PRESSED/HELD).
- Sub-module btn_press_fsm: one instance per button (FSM + tick counter + emit outputs).
- Divider, pending slots, arbiter and drop logic stay in the top.

Test Plan:
Use N_BTN=4, TICK_DIV=4, LONG_TICKS=8, REPEAT_TICKS=4, evt_ready=1 unless stated.
- Reset mid-stream: assert rst while evt_valid=1 -> evt_valid, drop_flag, sample_tick = 0 immediately. First tick after release occurs 4 clks later.
- Short press: btn_db[2]=1 for 3 ticks then 0 -> (id 2, PRESS) then (id 2, RELEASE). With RELEASE_EVT_EN undefined -> PRESS only.
- Long hold: btn_db[0]=1 for 20 ticks -> PRESS at tick 0, LONG at tick 8, REPEAT at ticks 12 and 16, RELEASE at tick 20. No drops.
- Simultaneous press: btn_db=4'b1111 in one tick, rr_ptr=1 -> ids 1,2,3,0 accepted on consecutive clks, all PRESS.
- Backpressure: evt_ready=0, button 3 PRESS then RELEASE while its slot is full -> drop_flag=1. After evt_ready=1 only PRESS for id 3 arrives. drop_clr -> drop_flag=0.
- Stable hold: evt_ready=0 for 10 clks with evt_valid=1 -> evt_id and evt_type unchanged throughout.
